rf_wport_arb: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 32x32 register file. The single write port (A3/WD3/write enable) is shared between the pipeline writeback stage and the long-latency multiply/divide unit. Mul/div results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter forces a one-cycle writeback stall when the FIFO has waited too long. A busy mask of in-flight mul/div destinations is exported to the hazard unit.

---
 rtl/rf_wport_arb.sv | 126 ++++++++++++
 tb/tb_rf_wport_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered mul/div results,
// with starvation-forced drain and busy mask. Optional same-cycle bypass: RF_ARB_BYPASS_EN.
module rf_wport_arb #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_dst,
    input  logic        md_valid,
    input  logic [4:0]  md_dst,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        RegWriteRF,
    output logic        StallWB,
    output logic [31:0] busy_mask
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAXWAIT + 1);

    logic [4:0]    r_dst [DEPTH];
    logic [31:0]   r_dat [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic [CW-1:0] r_wait;
    logic          r_stall;
    logic          r_ready;
    logic [31:0]   r_busy;

    logic          w_pipe_req, w_empty, w_push, w_store, w_pop, w_bypass, w_we;
    logic [4:0]    w_a3;
    logic [31:0]   w_wd;
    logic [PW:0]   w_count_next;
    logic [31:0]   w_busy_next;

    always_comb begin
        w_pipe_req = RegWriteW && (WriteRegW != '0);
        w_empty    = (r_count == '0);
        w_push     = md_valid && r_ready;
        w_bypass   = 1'b0;
        w_pop      = 1'b0;
        w_we       = 1'b0;
        w_a3       = '0;
        w_wd       = '0;
`ifdef RF_ARB_BYPASS_EN
        w_bypass   = rst_n && w_push && (md_dst != '0) && w_empty && !w_pipe_req && !r_stall;
`endif
        // Outputs are forced idle while in reset so no write leaks through.
        if (rst_n) begin
            if (!w_empty && (r_stall || !w_pipe_req)) begin
                w_pop = 1'b1;
                w_we  = 1'b1;
                w_a3  = r_dst[r_rptr];
                w_wd  = r_dat[r_rptr];
            end else if (w_pipe_req) begin
                w_we  = 1'b1;
                w_a3  = WriteRegW;
                w_wd  = ResultW;
            end else if (w_bypass) begin
                w_we  = 1'b1;
                w_a3  = md_dst;
                w_wd  = md_data;
            end
        end
        w_store      = w_push && (md_dst != '0) && !w_bypass;
        w_count_next = r_count + (PW+1)'(w_store) - (PW+1)'(w_pop);

        // Set after clear so a same-cycle issue keeps the bit.
        w_busy_next = r_busy;
        if (w_pop || w_bypass)
            w_busy_next[w_a3] = 1'b0;
        if (md_issue && (md_issue_dst != '0))
            w_busy_next[md_issue_dst] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= '0;
            r_stall <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= '0;
        end else begin
            if (w_store)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= w_count_next;
            r_ready <= (w_count_next != (PW+1)'(DEPTH));
            r_busy  <= w_busy_next;
            if (w_empty || w_pop) begin
                r_wait  <= '0;
                r_stall <= 1'b0;
            end else if (r_wait == CW'(MAXWAIT - 1)) begin
                r_wait  <= '0;
                r_stall <= 1'b1;
            end else begin
                r_wait  <= r_wait + CW'(1);
                r_stall <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_dst[r_wptr] <= md_dst;
            r_dat[r_wptr] <= md_data;
        end
    end

    assign md_ready   = r_ready;
    assign StallWB    = r_stall;
    assign busy_mask  = r_busy;
    assign RegWriteRF = w_we;
    assign A3         = w_a3;
    assign WD3        = w_wd;
endmodule

// File: tb/tb_rf_wport_arb.sv
// Scoreboard bench for rf_wport_arb (default build, DEPTH=2, MAXWAIT=4): expected
// register-file writes are queued with their cycle; a negedge monitor matches them.
module tb_rf_wport_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_dst = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_dst = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        RegWriteRF;
    logic        StallWB;
    logic [31:0] busy_mask;

    rf_wport_arb #(.DEPTH(2), .MAXWAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .md_issue(md_issue), .md_issue_dst(md_issue_dst),
        .md_valid(md_valid), .md_dst(md_dst), .md_data(md_data),
        .md_ready(md_ready), .A3(A3), .WD3(WD3), .RegWriteRF(RegWriteRF),
        .StallWB(StallWB), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expw(input int unsigned c, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.a3 = a; e.wd = d;
        q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [4:0] r, input logic [31:0] d);
        RegWriteW = en; WriteRegW = r; ResultW = d;
    endtask

    task automatic md(input logic v, input logic [4:0] d, input logic [31:0] x,
                      input logic iss, input logic [4:0] idst);
        md_valid = v; md_dst = d; md_data = x; md_issue = iss; md_issue_dst = idst;
    endtask

    // Monitor: flag overdue expectations, then match any presented write.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_write_cycle", cyc, e.cyc);
        end
        if (RegWriteRF) begin
            if (q.size() == 0) begin
                chk("unexpected_write_A3", {27'd0, A3}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_A3", {27'd0, A3}, {27'd0, e.a3});
                chk("write_WD3", WD3, e.wd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        step; step;
        rst_n = 1'b1;
        // Reset, then idle
        step; #1;
        chk("idle_RegWriteRF", {31'd0, RegWriteRF}, 32'd0);
        chk("idle_md_ready", {31'd0, md_ready}, 32'd1);
        chk("idle_busy_mask", busy_mask, 32'd0);
        chk("idle_StallWB", {31'd0, StallWB}, 32'd0);

        // Pipeline-only write, then a write to register 0
        step; pipe(1, 5'd5, 32'h1234); expw(cyc, 5'd5, 32'h1234);
        step; pipe(1, 5'd0, 32'h5678); #1;
        chk("r0_RegWriteRF", {31'd0, RegWriteRF}, 32'd0);
        step; pipe(0, 5'd0, 32'd0);

        // Mul/div issue and drain
        step; md(0, 5'd0, 32'd0, 1, 5'd8);
        step; md(1, 5'd8, 32'hCAFE, 0, 5'd0); expw(cyc + 1, 5'd8, 32'hCAFE); #1;
        chk("issue_busy8", {31'd0, busy_mask[8]}, 32'd1);
        step; md(0, 5'd0, 32'd0, 0, 5'd0);
        step; #1;
        chk("drain_busy8", {31'd0, busy_mask[8]}, 32'd0);

        // Starvation: one queued result, pipeline writes every cycle
        step; c0 = cyc;
        md(1, 5'd9, 32'h9999, 1, 5'd9);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step;
            if (i == 1) md(0, 5'd0, 32'd0, 0, 5'd0);
            pipe(1, 5'(10 + i), 32'(i)); expw(cyc, 5'(10 + i), 32'(i)); #1;
            chk("starve_nostall", {31'd0, StallWB}, 32'd0);
        end
        step; pipe(1, 5'd15, 32'd5); #1;
        chk("starve_stall_cycle", cyc - c0, 32'd5);
        chk("starve_StallWB", {31'd0, StallWB}, 32'd1);
        expw(cyc, 5'd9, 32'h9999);
        step; expw(cyc, 5'd15, 32'd5); #1;
        chk("starve_release", {31'd0, StallWB}, 32'd0);
        chk("starve_busy9", {31'd0, busy_mask[9]}, 32'd0);
        step; pipe(0, 5'd0, 32'd0);
        step;

        // Fill the FIFO under continuous pipeline writes
        step; pipe(1, 5'd30, 32'h30); expw(cyc, 5'd30, 32'h30);
        md(1, 5'd3, 32'hA1, 1, 5'd3);
        step; pipe(1, 5'd31, 32'h31); expw(cyc, 5'd31, 32'h31);
        md(1, 5'd8, 32'hA2, 1, 5'd8); #1;
        chk("fill_ready_one", {31'd0, md_ready}, 32'd1);
        step; pipe(1, 5'd32 - 5'd1 - 5'd29, 32'h32); expw(cyc, 5'd2, 32'h32);
        md(0, 5'd0, 32'd0, 0, 5'd0); #1;
        chk("full_ready", {31'd0, md_ready}, 32'd0);
        step; pipe(1, 5'd13, 32'h33); expw(cyc, 5'd13, 32'h33);
        step; pipe(1, 5'd14, 32'h34); expw(cyc, 5'd14, 32'h34); #1;
        chk("full_nostall", {31'd0, StallWB}, 32'd0);
        step; pipe(1, 5'd16, 32'h35); expw(cyc, 5'd3, 32'hA1); #1;
        chk("full_StallWB", {31'd0, StallWB}, 32'd1);
        chk("full_ready_stall", {31'd0, md_ready}, 32'd0);
        step; expw(cyc, 5'd16, 32'h35); #1;
        chk("pop_ready", {31'd0, md_ready}, 32'd1);
        step; pipe(0, 5'd0, 32'd0); md(0, 5'd0, 32'd0, 1, 5'd8); expw(cyc, 5'd8, 32'hA2);
        step; md(0, 5'd0, 32'd0, 0, 5'd0); #1;
        chk("set_wins_busy", busy_mask, 32'h0000_0100);

        // Async reset with two entries queued
        step; pipe(1, 5'd20, 32'h20); expw(cyc, 5'd20, 32'h20);
        md(1, 5'd21, 32'hB1, 1, 5'd21);
        step; pipe(1, 5'd22, 32'h22); expw(cyc, 5'd22, 32'h22);
        md(1, 5'd23, 32'hB2, 1, 5'd23); #1;
        chk("pre_reset_busy", busy_mask, 32'h0020_0100);
        step; md(0, 5'd0, 32'd0, 0, 5'd0); pipe(1, 5'd24, 32'h24);
        rst_n = 1'b0; #1;
        chk("rst_RegWriteRF", {31'd0, RegWriteRF}, 32'd0);
        chk("rst_busy_mask", busy_mask, 32'd0);
        chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
        step; pipe(0, 5'd0, 32'd0);
        step; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step;
        #1;
        chk("post_reset_busy", busy_mask, 32'd0);
        chk("post_reset_StallWB", {31'd0, StallWB}, 32'd0);
        step; step;
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
